// File: rtl/aes128_encrypt_iterative_if.sv
// Block handshake between the packet layer (master) and the AES encrypt core (slave).
// Carries plaintext/key in, ciphertext out, each with valid/ready flow control.
interface aes128_encrypt_iterative_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes128_encrypt_iterative.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion; out_valid 10 cycles after accept.
// One block in flight; ciphertext held indefinitely under out_ready backpressure, in_ready low until it drains.
module aes128_encrypt_iterative (
  input  logic                        clk,
  input  logic                        rst_n,
  aes128_encrypt_iterative_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} fsmState_t;

  fsmState_t        fsm, fsmNext;
  logic [127:0]     stateReg, rkeyReg, ctReg;
  logic [3:0]       round;
  logic [7:0]       rcon;
  logic [127:0]     nextKey, roundOut;
  logic             lastRound;
  logic [0:15][7:0] stBytes, sbBytes, srBytes, mcBytes;
  logic [31:0]      kTmp, n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign lastRound = (round == 4'd10);
  assign stBytes   = stateReg;

  always_comb begin
    kTmp    = subWord({rkeyReg[23:0], rkeyReg[31:24]}) ^ {rcon, 24'h000000};
    n0      = rkeyReg[127:96] ^ kTmp;
    n1      = rkeyReg[95:64]  ^ n0;
    n2      = rkeyReg[63:32]  ^ n1;
    n3      = rkeyReg[31:0]   ^ n2;
    nextKey = {n0, n1, n2, n3};
  end

  // Byte index is row + 4*column; ShiftRows rotates row r left by r columns.
  always_comb begin
    sbBytes = '0;
    srBytes = '0;
    mcBytes = '0;
    for (int i = 0; i < 16; i++) sbBytes[i] = sbox(stBytes[i]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        srBytes[4*c + r] = sbBytes[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      mcBytes[4*c]     = xtime(srBytes[4*c]) ^ xtime(srBytes[4*c+1]) ^ srBytes[4*c+1]
                       ^ srBytes[4*c+2] ^ srBytes[4*c+3];
      mcBytes[4*c + 1] = srBytes[4*c] ^ xtime(srBytes[4*c+1]) ^ xtime(srBytes[4*c+2])
                       ^ srBytes[4*c+2] ^ srBytes[4*c+3];
      mcBytes[4*c + 2] = srBytes[4*c] ^ srBytes[4*c+1] ^ xtime(srBytes[4*c+2])
                       ^ xtime(srBytes[4*c+3]) ^ srBytes[4*c+3];
      mcBytes[4*c + 3] = xtime(srBytes[4*c]) ^ srBytes[4*c] ^ srBytes[4*c+1]
                       ^ srBytes[4*c+2] ^ xtime(srBytes[4*c+3]);
    end
    roundOut = (lastRound ? srBytes : mcBytes) ^ nextKey;
  end

  always_comb begin
    fsmNext = fsm;
    case (fsm)
      IDLE:    if (bus.in_valid)  fsmNext = BUSY;
      BUSY:    if (lastRound)     fsmNext = DONE;
      DONE:    if (bus.out_ready) fsmNext = IDLE;
      default:                    fsmNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsmNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= '0;
      rkeyReg  <= '0;
      ctReg    <= '0;
      round    <= 4'd0;
      rcon     <= 8'h01;
    end else begin
      case (fsm)
        IDLE: if (bus.in_valid) begin
          stateReg <= bus.plaintext ^ bus.key;
          rkeyReg  <= bus.key;
          round    <= 4'd1;
          rcon     <= 8'h01;
        end
        BUSY: begin
          stateReg <= roundOut;
          rkeyReg  <= nextKey;
          rcon     <= xtime(rcon);
          round    <= round + 4'd1;
          if (lastRound) ctReg <= roundOut;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (fsm == IDLE);
  assign bus.out_valid  = (fsm == DONE);
  assign bus.busy       = (fsm != IDLE);
  assign bus.ciphertext = ctReg;

endmodule

// File: tb/tb_aes128_encrypt_iterative.sv
// Directed + randomized bench for the iterative AES-128 encryptor against a table-driven FIPS-197 model.
module tb_aes128_encrypt_iterative;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [7:0] sboxT [256];

  aes128_encrypt_iterative_if bus ();

  aes128_encrypt_iterative dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box generated by walking the multiplicative group (p*3, q/3) rather than computing inverses.
  task automatic buildSbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sboxT[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end
    sboxT[0] = 8'h63;
  endtask

  function automatic logic [7:0] mul2(input logic [7:0] b);
    int v;
    v = int'(b) * 2;
    if (v > 255) v = v ^ 'h11b;
    return v[7:0];
  endfunction

  function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxT[tmp[31:24]], sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = mul2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a block, let it run with the sink ready, return ciphertext and accept-to-valid latency.
  task automatic doBlock(input logic [127:0] pt, input logic [127:0] k,
                         output logic [127:0] ct, output int lat);
    int n;
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    bus.in_valid  = 1'b0;
    bus.plaintext = ~pt;
    bus.key       = ~k;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    ct = bus.ciphertext;
    tick();
  endtask

  initial begin
    logic [127:0] ct, ct1, pt, k, pt2, k2;
    int lat, accA, accB, n;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    buildSbox();
    tick(); tick();
    chk("rst_in_ready",   bus.in_ready,   1);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_busy",       bus.busy,       0);
    chk("rst_ciphertext", bus.ciphertext, 0);
    rst_n = 1'b1;
    tick();

    doBlock(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, ct, lat);
    chk("c1_latency", lat, 10);
    chk("c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // FIPS-197 appendix B, with a peek at the state after round 1.
    bus.plaintext = 128'h3243f6a8885a308d313198a2e0370734;
    bus.key       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("b_round1_state", dut.stateReg, 128'ha49c7ff2689f352b6b5bea43026a5049);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("b_latency", lat, 10);
    chk("b_ct", bus.ciphertext, 128'h3925841d02dc09fbdc118597196a0b32);
    tick();

    // Backpressure: sink stalls for 7 cycles.
    bus.plaintext = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("bp_latency", n, 10);
    for (int i = 0; i < 7; i++) begin
      chk("bp_ct_hold",  bus.ciphertext, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid",    bus.out_valid, 1);
      bus.in_valid = (i % 2 == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_valid",    bus.out_valid, 0);
    chk("bp_ct_retained",      bus.ciphertext, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    // Back-to-back with in_valid held high and the bus switched to the second vector mid-block.
    pt  = 128'h00112233445566778899aabbccddeeff;
    k   = 128'h000102030405060708090a0b0c0d0e0f;
    pt2 = 128'h3243f6a8885a308d313198a2e0370734;
    k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    tick();
    accA = cyc;
    bus.plaintext = pt2;
    bus.key       = k2;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    ct1 = bus.ciphertext;
    chk("b2b_first_ct", ct1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    tick();
    accB = cyc;
    chk("b2b_accept_gap", accB - accA, 12);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      bus.plaintext = rnd128();
      tick();
      n++;
    end
    chk("b2b_second_ct", bus.ciphertext, 128'h3925841d02dc09fbdc118597196a0b32);
    tick();

    // Asynchronous reset during round 5.
    bus.plaintext = rnd128();
    bus.key       = rnd128();
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid",  bus.out_valid,  0);
    chk("arst_in_ready",   bus.in_ready,   1);
    chk("arst_ciphertext", bus.ciphertext, 0);
    chk("arst_busy",       bus.busy,       0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("arst_no_valid_pulse", seen, 0);
    pt = rnd128();
    k  = rnd128();
    doBlock(pt, k, ct, lat);
    chk("arst_after_latency", lat, 10);
    chk("arst_after_ct", ct, aesRef(pt, k));

    // Spurious in_valid and key/plaintext churn while busy.
    pt = rnd128();
    k  = rnd128();
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.key       = rnd128();
      bus.plaintext = rnd128();
      tick();
      n++;
    end
    chk("spur_latency", n, 10);
    chk("spur_ct", bus.ciphertext, aesRef(pt, k));
    bus.in_valid = 1'b0;
    tick();

    // Random vectors with a random sink stall.
    for (int i = 0; i < 6; i++) begin
      pt = rnd128();
      k  = rnd128();
      bus.plaintext = pt;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
      chk("rand_latency", n, 10);
      repeat ($urandom_range(0, 4)) tick();
      chk("rand_ct", bus.ciphertext, aesRef(pt, k));
      bus.out_ready = 1'b1;
      tick();
      chk("rand_drain", bus.in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
